// File: rtl/cmd_queue_arbiter.sv
// ============================================================================
// Module   : cmd_queue_arbiter
// Brief    : Round-robin, burst-bounded write arbiter and read scheduler for
//            the negedge-clocked CPU command queue; tracks queue occupancy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_queue_arbiter #(
  parameter int DATA_W    = 30,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 5,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  output logic              q_write,
  output logic [DATA_W-1:0] q_data,
  output logic              q_read,
  input  logic              cons_ready,
  output logic              out_valid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] C_BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0]   C_DEPTH      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   C_ONE        = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_b;      // 1: B owned last, so A wins the next tie
  logic                 w_last_b_nxt;
  logic [BURST_W-1:0]   r_burst;
  logic [BURST_W-1:0]   w_burst_nxt;
  logic [CNT_W-1:0]     r_count;
  logic                 w_own_req;
  logic                 w_oth_req;
  logic                 w_wr;
  logic                 w_rd;

  assign count = r_count;
  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign gnt_a = (r_state == ST_OWN_A) && req_a && !full;
  assign gnt_b = (r_state == ST_OWN_B) && req_b && !full;
  assign w_wr  = gnt_a || gnt_b;
  assign w_rd  = cons_ready && !empty;

  assign w_own_req = (r_state == ST_OWN_B) ? req_b : req_a;
  assign w_oth_req = (r_state == ST_OWN_B) ? req_a : req_b;

  always_comb begin
    w_state_nxt  = r_state;
    w_last_b_nxt = r_last_b;
    w_burst_nxt  = r_burst;
    case (r_state)
      ST_IDLE: begin
        if (req_a && (!req_b || r_last_b)) begin
          w_state_nxt  = ST_OWN_A;
          w_last_b_nxt = 1'b0;
          w_burst_nxt  = '0;
        end else if (req_b) begin
          w_state_nxt  = ST_OWN_B;
          w_last_b_nxt = 1'b1;
          w_burst_nxt  = '0;
        end
      end
      ST_OWN_A, ST_OWN_B: begin
        // Ownership and burst position freeze while the queue is full.
        if (!full) begin
          if (!w_own_req) begin
            if (w_oth_req) begin
              w_state_nxt  = (r_state == ST_OWN_A) ? ST_OWN_B : ST_OWN_A;
              w_last_b_nxt = (r_state == ST_OWN_A);
              w_burst_nxt  = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else if (r_burst == C_BURST_LAST) begin
            w_burst_nxt = '0;
            if (w_oth_req) begin
              w_state_nxt  = (r_state == ST_OWN_A) ? ST_OWN_B : ST_OWN_A;
              w_last_b_nxt = (r_state == ST_OWN_A);
            end
          end else begin
            w_burst_nxt = r_burst + BURST_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_last_b <= 1'b1;
      r_burst  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_last_b <= w_last_b_nxt;
      r_burst  <= w_burst_nxt;
    end
  end

  // Queue strobes are launched here so they are stable at the queue's negedge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_write   <= 1'b0;
      q_data    <= '0;
      q_read    <= 1'b0;
      out_valid <= 1'b0;
      r_count   <= '0;
    end else begin
      q_write   <= w_wr;
      q_read    <= w_rd;
      out_valid <= q_read;
      if (w_wr) begin
        q_data <= gnt_a ? data_a : data_b;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_queue_arbiter.sv
// ============================================================================
// Module   : tb_cmd_queue_arbiter
// Brief    : Directed self-checking bench for cmd_queue_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_queue_arbiter;

  localparam int DATA_W = 30;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_a, req_b, cons_ready;
  logic [DATA_W-1:0] data_a, data_b;
  logic              gnt_a, gnt_b, q_write, q_read, out_valid, full, empty;
  logic [DATA_W-1:0] q_data;
  logic [CNT_W-1:0]  count;

  int n_vec = 0;
  int n_err = 0;

  cmd_queue_arbiter #(
    .DATA_W(DATA_W), .DEPTH(16), .CNT_W(CNT_W), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
    .q_write(q_write), .q_data(q_data), .q_read(q_read),
    .cons_ready(cons_ready), .out_valid(out_valid),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic ea, eb;
    reset = 1'b0; req_a = 1'b1; req_b = 1'b1; cons_ready = 1'b0;
    data_a = '0; data_b = '0;
    #3;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_q_write", q_write, 0);
    chk("rst_q_read", q_read, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q_data", q_data, 0);
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Producer A only, three words
    req_a = 1'b1; data_a = 30'h1;
    #1 chk("t1_idle_gnt_a", gnt_a, 0);
    tick;
    chk("t1_qw_before", q_write, 0);
    chk("t1_gnt_a_c1", gnt_a, 1);
    chk("t1_gnt_b_c1", gnt_b, 0);
    tick;
    chk("t1_qw1", q_write, 1); chk("t1_qd1", q_data, 30'h1); chk("t1_cnt1", count, 1);
    data_a = 30'h2;
    #1 chk("t1_gnt_a_c2", gnt_a, 1);
    tick;
    chk("t1_qd2", q_data, 30'h2); chk("t1_cnt2", count, 2);
    data_a = 30'h3;
    #1 chk("t1_gnt_a_c3", gnt_a, 1);
    chk("t1_gnt_b_c3", gnt_b, 0);
    tick;
    chk("t1_qd3", q_data, 30'h3); chk("t1_cnt3", count, 3);
    req_a = 1'b0;
    #1 chk("t1_gnt_a_off", gnt_a, 0);
    tick;
    chk("t1_qw_off", q_write, 0); chk("t1_cnt_hold", count, 3); chk("t1_qd_hold", q_data, 30'h3);

    // Both producers held from reset release: 4 A, 4 B, then A again
    do_reset;
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      data_a = 30'h100 + 30'(c);
      data_b = 30'h200 + 30'(c);
      #1;
      ea = (c >= 1 && c <= 4) || (c >= 9);
      eb = (c >= 5 && c <= 8);
      chk($sformatf("t2_gnt_a_c%0d", c), gnt_a, 32'(ea));
      chk($sformatf("t2_gnt_b_c%0d", c), gnt_b, 32'(eb));
      tick;
      chk($sformatf("t2_qw_c%0d", c), q_write, 32'(ea | eb));
      if (ea || eb)
        chk($sformatf("t2_qd_c%0d", c), q_data, ea ? 32'h100 + 32'(c) : 32'h200 + 32'(c));
    end
    chk("t2_count", count, 12);
    req_a = 1'b0; req_b = 1'b0;

    // A streams 17 words into a stalled queue
    do_reset;
    req_a = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      data_a = 30'h300 + 30'(c);
      #1 chk($sformatf("t3_gnt_a_c%0d", c), gnt_a, 32'(c >= 1 && c <= 16));
      tick;
    end
    chk("t3_count_full", count, 16);
    chk("t3_full", full, 1);
    chk("t3_qw_stall", q_write, 0);
    cons_ready = 1'b1;
    #1 chk("t3_gnt_a_full", gnt_a, 0);
    tick;
    chk("t3_q_read", q_read, 1); chk("t3_count15", count, 15); chk("t3_qw_none", q_write, 0);
    cons_ready = 1'b0;
    #1 chk("t3_gnt_a_resume", gnt_a, 1);
    chk("t3_not_full", full, 0);
    tick;
    chk("t3_qw17", q_write, 1); chk("t3_qd17", q_data, 30'h311);
    chk("t3_count16", count, 16); chk("t3_out_valid", out_valid, 1); chk("t3_q_read_off", q_read, 0);
    req_a = 1'b0;

    // Simultaneous write and read at count 5
    do_reset;
    req_a = 1'b1; data_a = 30'h55;
    repeat (6) tick;
    chk("t4_count5", count, 5);
    cons_ready = 1'b1;
    #1 chk("t4_gnt_a", gnt_a, 1);
    tick;
    chk("t4_qw", q_write, 1); chk("t4_qr", q_read, 1); chk("t4_count_same", count, 5);
    req_a = 1'b0; cons_ready = 1'b0;
    tick;
    chk("t4_out_valid", out_valid, 1); chk("t4_count_after", count, 5);

    // Empty queue with consumer ready; single word flows through
    do_reset;
    cons_ready = 1'b1; req_a = 1'b1; data_a = 30'h2AAAAAAA;
    tick;
    chk("t5_qr_empty", q_read, 0);
    chk("t5_gnt_a", gnt_a, 1);
    tick;
    chk("t5_qw_N", q_write, 1); chk("t5_qd_N", q_data, 30'h2AAAAAAA);
    chk("t5_qr_N", q_read, 0); chk("t5_cnt_N", count, 1);
    req_a = 1'b0;
    tick;
    chk("t5_qr_N1", q_read, 1); chk("t5_qw_N1", q_write, 0); chk("t5_cnt_N1", count, 0);
    chk("t5_ov_N1", out_valid, 0);
    tick;
    chk("t5_ov_N2", out_valid, 1); chk("t5_qr_N2", q_read, 0); chk("t5_empty", empty, 1);
    cons_ready = 1'b0;

    // Asynchronous reset mid-burst at count 7
    do_reset;
    req_a = 1'b1; data_a = 30'h77;
    repeat (8) tick;
    cons_ready = 1'b1;
    tick;
    chk("t6_count7", count, 7);
    chk("t6_qr_pre", q_read, 1);
    chk("t6_gnt_pre", gnt_a, 1);
    reset = 1'b0;
    #1;
    chk("t6_gnt_a", gnt_a, 0); chk("t6_qw", q_write, 0); chk("t6_qr", q_read, 0);
    chk("t6_count", count, 0); chk("t6_empty", empty, 1); chk("t6_ov", out_valid, 0);
    reset = 1'b1;
    #1 chk("t6_idle_gnt", gnt_a, 0);
    tick;
    chk("t6_own_a_gnt", gnt_a, 1);
    chk("t6_qr_after", q_read, 0);
    req_a = 1'b0; cons_ready = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
